// File: rtl/amstrad_ga_ioregs.sv
// Amstrad CPC gate-array I/O register block: decodes Z80 OUT writes into the
// gate-array, ROM-select and Plus RMR2 registers, and tracks the ASIC unlock sequence.
module amstrad_ga_ioregs #(
    parameter int PLUS_EN    = 1,
    parameter int UNLOCK_LEN = 17
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        io_WR,
    input  logic [15:0] A,
    input  logic [7:0]  D,
    input  logic        ram64k,
    input  logic        plus_mode,
    output logic [7:0]  ram_config,
    output logic [7:0]  mrer,
    output logic [7:0]  rom_select,
    output logic [7:0]  rmr2,
    output logic [4:0]  pen,
    output logic [4:0]  colour,
    output logic        colour_we,
    output logic        irq_ack,
    output logic        asic_unlocked,
    output logic        wr_stb
);

    typedef enum logic [1:0] {IDLE, SEQ, UNLOCKED} state_e;

    localparam logic       PLUS_ON  = (PLUS_EN != 0);
    localparam logic [4:0] LAST_IDX = 5'(UNLOCK_LEN - 1);

    state_e     state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic       unlocked_q, unlocked_d;
    logic       wr_q, armed_q;
    logic [7:0] ramConfig_q, ramConfig_d, mrer_q, mrer_d;
    logic [7:0] romSelect_q, romSelect_d, rmr2_q, rmr2_d;
    logic [4:0] pen_q, pen_d, colour_q, colour_d;
    logic       colourWe_q, colourWe_d, irqAck_q, irqAck_d, wrStb_q, wrStb_d;
    logic       plusOn, wrEdge, gaSel, crtcSel, unlockedOut;
    logic       unusedAddrBits;

    function automatic logic [7:0] unlockByte(input logic [4:0] k);
        case (k)
            5'd0:    return 8'hFF;
            5'd1:    return 8'h00;
            5'd2:    return 8'hFF;
            5'd3:    return 8'h77;
            5'd4:    return 8'hB3;
            5'd5:    return 8'h51;
            5'd6:    return 8'hA8;
            5'd7:    return 8'hD4;
            5'd8:    return 8'h62;
            5'd9:    return 8'h39;
            5'd10:   return 8'h9C;
            5'd11:   return 8'h46;
            5'd12:   return 8'h2B;
            5'd13:   return 8'h15;
            5'd14:   return 8'h8A;
            5'd15:   return 8'hCD;
            5'd16:   return 8'hEE;
            default: return 8'h00;
        endcase
    endfunction

    // armed_q blocks a write until io_WR has been seen low after reset
    assign plusOn         = PLUS_ON && plus_mode;
    assign wrEdge         = io_WR && !wr_q && armed_q;
    assign gaSel          = !A[15] && A[14];
    assign crtcSel        = !A[14] && (A[9:8] == 2'b00);
    assign unlockedOut    = unlocked_q && plusOn;
    assign unusedAddrBits = ^{A[12:10], A[7:0]};

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        unlocked_d = unlocked_q;
        if (!plusOn) begin
            state_d    = IDLE;
            idx_d      = 5'd0;
            unlocked_d = 1'b0;
        end else if (wrEdge && crtcSel) begin
            if (state_q == UNLOCKED) begin
                if (D == 8'hFF) begin
                    state_d = SEQ;
                    idx_d   = 5'd1;
                end
            end else if (D == unlockByte(idx_q)) begin
                if (idx_q == LAST_IDX) begin
                    state_d    = UNLOCKED;
                    idx_d      = 5'd0;
                    unlocked_d = 1'b1;
                end else begin
                    state_d = SEQ;
                    idx_d   = idx_q + 5'd1;
                end
            end else begin
                // Only a wrong final byte relocks; earlier mismatches just resync
                if (idx_q == LAST_IDX) unlocked_d = 1'b0;
                state_d = (D == 8'hFF) ? SEQ : IDLE;
                idx_d   = (D == 8'hFF) ? 5'd1 : 5'd0;
            end
        end
    end

    always_comb begin
        ramConfig_d = ramConfig_q;
        mrer_d      = mrer_q;
        romSelect_d = romSelect_q;
        rmr2_d      = rmr2_q;
        pen_d       = pen_q;
        colour_d    = colour_q;
        colourWe_d  = 1'b0;
        irqAck_d    = 1'b0;
        wrStb_d     = wrEdge;
        if (wrEdge) begin
            if (!A[13]) romSelect_d = D;
            if (gaSel) begin
                case (D[7:6])
                    2'b00: pen_d = D[4] ? 5'h10 : {1'b0, D[3:0]};
                    2'b01: begin
                        colour_d   = D[4:0];
                        colourWe_d = 1'b1;
                    end
                    2'b10: begin
                        if (unlockedOut && D[5]) begin
                            rmr2_d = D;
                        end else begin
                            mrer_d   = D;
                            irqAck_d = D[4];
                        end
                    end
                    default: if (!ram64k) ramConfig_d = D;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= 5'd0;
            unlocked_q  <= 1'b0;
            wr_q        <= 1'b0;
            armed_q     <= 1'b0;
            ramConfig_q <= 8'h00;
            mrer_q      <= 8'h00;
            romSelect_q <= 8'h00;
            rmr2_q      <= 8'h00;
            pen_q       <= 5'h00;
            colour_q    <= 5'h00;
            colourWe_q  <= 1'b0;
            irqAck_q    <= 1'b0;
            wrStb_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            unlocked_q  <= unlocked_d;
            wr_q        <= io_WR;
            armed_q     <= armed_q | ~io_WR;
            ramConfig_q <= ramConfig_d;
            mrer_q      <= mrer_d;
            romSelect_q <= romSelect_d;
            rmr2_q      <= rmr2_d;
            pen_q       <= pen_d;
            colour_q    <= colour_d;
            colourWe_q  <= colourWe_d;
            irqAck_q    <= irqAck_d;
            wrStb_q     <= wrStb_d;
        end
    end

    assign ram_config    = ramConfig_q;
    assign mrer          = mrer_q;
    assign rom_select    = romSelect_q;
    assign rmr2          = rmr2_q;
    assign pen           = pen_q;
    assign colour        = colour_q;
    assign colour_we     = colourWe_q;
    assign irq_ack       = irqAck_q;
    assign asic_unlocked = unlockedOut;
    assign wr_stb        = wrStb_q;

endmodule

// File: tb/tb_amstrad_ga_ioregs.sv
// Testbench for amstrad_ga_ioregs: directed scenarios plus randomized writes
// checked against a rule-level model of the register decode and unlock sequence.
module tb_amstrad_ga_ioregs;

    logic        CLK = 1'b0;
    logic        reset, io_WR, ram64k, plus_mode;
    logic [15:0] A;
    logic [7:0]  D;
    logic [7:0]  ram_config, mrer, rom_select, rmr2;
    logic [4:0]  pen, colour;
    logic        colour_we, irq_ack, asic_unlocked, wr_stb;

    int testsRun = 0;
    int testsFailed = 0;

    logic [7:0] tbl [17] = '{8'hFF, 8'h00, 8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4,
                             8'h62, 8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD, 8'hEE};

    // Reference model state: register contents, strobes expected now, unlock progress
    logic [7:0] mRam, mMrer, mRom, mRmr2;
    logic [4:0] mPen, mColour;
    logic       eCw, eIrq, eWr, mUnl;
    int         mPos;
    logic [45:0] actVec;

    amstrad_ga_ioregs dut (
        .CLK(CLK), .reset(reset), .io_WR(io_WR), .A(A), .D(D),
        .ram64k(ram64k), .plus_mode(plus_mode),
        .ram_config(ram_config), .mrer(mrer), .rom_select(rom_select), .rmr2(rmr2),
        .pen(pen), .colour(colour), .colour_we(colour_we), .irq_ack(irq_ack),
        .asic_unlocked(asic_unlocked), .wr_stb(wr_stb)
    );

    always #5 CLK = ~CLK;

    assign actVec = {ram_config, mrer, rom_select, rmr2, pen, colour,
                     colour_we, irq_ack, asic_unlocked, wr_stb};

    function automatic logic [45:0] expVec();
        return {mRam, mMrer, mRom, mRmr2, mPen, mColour, eCw, eIrq, mUnl & plus_mode, eWr};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic modelReset();
        mRam = 0; mMrer = 0; mRom = 0; mRmr2 = 0; mPen = 0; mColour = 0;
        eCw = 0; eIrq = 0; eWr = 0; mUnl = 0; mPos = 0;
    endtask

    task automatic modelWrite(input logic [15:0] a, input logic [7:0] d);
        eWr = 1; eCw = 0; eIrq = 0;
        if (!a[13]) mRom = d;
        if (!a[15] && a[14]) begin
            case (d[7:6])
                2'b00: mPen = d[4] ? 5'h10 : {1'b0, d[3:0]};
                2'b01: begin mColour = d[4:0]; eCw = 1; end
                2'b10: if (plus_mode && mUnl && d[5]) mRmr2 = d;
                       else begin mMrer = d; eIrq = d[4]; end
                default: if (!ram64k) mRam = d;
            endcase
        end
        if (!a[14] && a[9:8] == 2'b00 && plus_mode) begin
            if (d == tbl[mPos]) begin
                mPos++;
                if (mPos == 17) begin mPos = 0; mUnl = 1; end
            end else begin
                if (mPos == 16) mUnl = 0;
                mPos = (d == 8'hFF) ? 1 : 0;
            end
        end
    endtask

    // Leaves the bench in the cycle after the write edge, io_WR still high
    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d);
        modelWrite(a, d);
        A = a; D = d; io_WR = 1'b1;
        tick();
    endtask

    task automatic releaseWrite();
        io_WR = 1'b0;
        tick();
        eWr = 0; eCw = 0; eIrq = 0;
    endtask

    task automatic sendCrtc(input logic [7:0] d);
        applyStimulus(16'hBC00, d);
        releaseWrite();
    endtask

    task automatic setPlus(input logic v);
        plus_mode = v;
        tick();
        if (!v) begin mUnl = 0; mPos = 0; end
    endtask

    task automatic test_reset();
        reset = 1; io_WR = 0; A = 0; D = 0; ram64k = 0; plus_mode = 0;
        tick(); tick();
        modelReset();
        testsRun++;
        if (actVec !== 46'd0) begin
            testsFailed++; $display("[TB] FAIL reset_outputs: got %h, expected 0", actVec);
        end
        reset = 0;
        tick();
    endtask

    task automatic test_ram_config();
        ram64k = 0;
        applyStimulus(16'h7F00, 8'hC5);
        testsRun++;
        if (ram_config !== 8'hC5 || wr_stb !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL ram_config_write: got %h/%b, expected C5/1", ram_config, wr_stb);
        end
        releaseWrite();
        testsRun++;
        if (wr_stb !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL wr_stb_width: got %b, expected 0", wr_stb);
        end
        ram64k = 1;
        applyStimulus(16'h7F00, 8'hC7);
        testsRun++;
        if (ram_config !== 8'hC5) begin
            testsFailed++; $display("[TB] FAIL ram64k_block: got %h, expected C5", ram_config);
        end
        releaseWrite();
        ram64k = 0;
    endtask

    task automatic test_rom_mrer();
        applyStimulus(16'h5F00, 8'h84);
        testsRun++;
        if (mrer !== 8'h84 || rom_select !== 8'h84 || irq_ack !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL mrer_rom_concurrent: got %h/%h/%b, expected 84/84/0", mrer, rom_select, irq_ack);
        end
        releaseWrite();
        applyStimulus(16'h5F00, 8'h94);
        testsRun++;
        if (irq_ack !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL irq_ack_pulse: got %b, expected 1", irq_ack);
        end
        releaseWrite();
        testsRun++;
        if (irq_ack !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL irq_ack_width: got %b, expected 0", irq_ack);
        end
    endtask

    task automatic test_pen_colour();
        applyStimulus(16'h7F00, 8'h0A);
        testsRun++;
        if (pen !== 5'h0A) begin
            testsFailed++; $display("[TB] FAIL pen_ink: got %h, expected 0A", pen);
        end
        releaseWrite();
        applyStimulus(16'h7F00, 8'h10);
        testsRun++;
        if (pen !== 5'h10) begin
            testsFailed++; $display("[TB] FAIL pen_border: got %h, expected 10", pen);
        end
        releaseWrite();
        applyStimulus(16'h7F00, 8'h4B);
        testsRun++;
        if (colour !== 5'h0B || colour_we !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL colour_write: got %h/%b, expected 0B/1", colour, colour_we);
        end
        releaseWrite();
        testsRun++;
        if (colour_we !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL colour_we_width: got %b, expected 0", colour_we);
        end
    endtask

    task automatic test_hold_level();
        applyStimulus(16'h7F00, 8'h8C);
        D = 8'h8D;
        tick(); tick();
        testsRun++;
        if (mrer !== 8'h8C || wr_stb !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL held_io_wr: got %h/%b, expected 8C/0", mrer, wr_stb);
        end
        releaseWrite();
    endtask

    task automatic test_unlock();
        setPlus(1);
        for (int k = 0; k < 16; k++) sendCrtc(tbl[k]);
        testsRun++;
        if (asic_unlocked !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL unlock_early: got %b, expected 0", asic_unlocked);
        end
        sendCrtc(tbl[16]);
        testsRun++;
        if (asic_unlocked !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL unlock_done: got %b, expected 1", asic_unlocked);
        end
        applyStimulus(16'h7F00, 8'hA3);
        testsRun++;
        if (rmr2 !== 8'hA3 || mrer !== 8'h8C) begin
            testsFailed++; $display("[TB] FAIL rmr2_write: got %h/%h, expected A3/8C", rmr2, mrer);
        end
        releaseWrite();
    endtask

    task automatic test_lock();
        sendCrtc(8'hFF);
        testsRun++;
        if (asic_unlocked !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL relock_start: got %b, expected 1", asic_unlocked);
        end
        for (int k = 1; k < 16; k++) sendCrtc(tbl[k]);
        sendCrtc(8'h00);
        testsRun++;
        if (asic_unlocked !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL relock_done: got %b, expected 0", asic_unlocked);
        end
        applyStimulus(16'h7F00, 8'hA5);
        testsRun++;
        if (mrer !== 8'hA5 || rmr2 !== 8'hA3) begin
            testsFailed++; $display("[TB] FAIL locked_mrer: got %h/%h, expected A5/A3", mrer, rmr2);
        end
        releaseWrite();
    endtask

    task automatic test_plus_off();
        for (int k = 0; k < 17; k++) sendCrtc(tbl[k]);
        setPlus(0);
        testsRun++;
        if (asic_unlocked !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL plus_off_gate: got %b, expected 0", asic_unlocked);
        end
        for (int k = 0; k < 17; k++) sendCrtc(tbl[k]);
        applyStimulus(16'h7F00, 8'hA3);
        testsRun++;
        if (mrer !== 8'hA3 || asic_unlocked !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL plus_off_mrer: got %h/%b, expected A3/0", mrer, asic_unlocked);
        end
        releaseWrite();
        setPlus(1);
        testsRun++;
        if (asic_unlocked !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL plus_off_cleared: got %b, expected 0", asic_unlocked);
        end
    endtask

    task automatic test_resync();
        for (int k = 0; k < 4; k++) sendCrtc(tbl[k]);
        sendCrtc(8'h00);
        sendCrtc(8'hFF);
        testsRun++;
        if (asic_unlocked !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL resync_locked: got %b, expected 0", asic_unlocked);
        end
        for (int k = 1; k < 17; k++) sendCrtc(tbl[k]);
        testsRun++;
        if (asic_unlocked !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL resync_seq1: got %b, expected 1", asic_unlocked);
        end
    endtask

    task automatic test_reset_midseq();
        for (int k = 0; k < 10; k++) sendCrtc(tbl[k]);
        A = 16'h7F00; D = 8'hC5; ram64k = 0; io_WR = 1; reset = 1;
        tick(); tick();
        modelReset();
        testsRun++;
        if (actVec !== 46'd0) begin
            testsFailed++; $display("[TB] FAIL midseq_reset: got %h, expected 0", actVec);
        end
        reset = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            testsRun++;
            if (wr_stb !== 1'b0 || ram_config !== 8'h00) begin
                testsFailed++; $display("[TB] FAIL release_high: got %b/%h, expected 0/00", wr_stb, ram_config);
            end
        end
        io_WR = 0;
        tick();
        applyStimulus(16'h7F00, 8'hC5);
        testsRun++;
        if (wr_stb !== 1'b1 || ram_config !== 8'hC5) begin
            testsFailed++; $display("[TB] FAIL rearm_write: got %b/%h, expected 1/C5", wr_stb, ram_config);
        end
        releaseWrite();
        for (int k = 10; k < 17; k++) sendCrtc(tbl[k]);
        testsRun++;
        if (asic_unlocked !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL seq_abandoned: got %b, expected 0", asic_unlocked);
        end
    endtask

    task automatic test_random();
        int burst = 0;
        logic [15:0] a;
        logic [7:0]  d;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) setPlus(!plus_mode);
            ram64k = 1'($urandom_range(0, 1));
            if (burst == 0 && $urandom_range(0, 24) == 0) burst = 17 + $urandom_range(0, 4);
            d = 8'($urandom);
            if (burst > 0) begin
                burst--;
                a = 16'hBC00;
                if ($urandom_range(0, 19) != 0) d = tbl[mPos];
            end else begin
                case ($urandom_range(0, 5))
                    0: a = 16'h7F00 | 16'($urandom_range(0, 255));
                    1: a = 16'h5F00;
                    2: a = 16'hDF00;
                    3: a = 16'hBC00;
                    4: a = 16'hBD00;
                    default: a = 16'($urandom);
                endcase
            end
            applyStimulus(a, d);
            testsRun++;
            if (actVec !== expVec()) begin
                testsFailed++; $display("[TB] FAIL rand_write A=%h D=%h: got %h, expected %h", a, d, actVec, expVec());
            end
            releaseWrite();
            testsRun++;
            if (actVec !== expVec()) begin
                testsFailed++; $display("[TB] FAIL rand_idle A=%h D=%h: got %h, expected %h", a, d, actVec, expVec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_ram_config();
        test_rom_mrer();
        test_pen_colour();
        test_hold_level();
        test_unlock();
        test_lock();
        test_plus_off();
        test_resync();
        test_reset_midseq();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
